// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, trap cause codes and mtvec mode encoding.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MIRQCFG  = 12'h7C0;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  localparam logic [4:0] CAUSE_PC_MISALIGN = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL     = 5'd2;
  localparam logic [4:0] CAUSE_LOAD_FAULT  = 5'd5;
  localparam logic [4:0] CAUSE_TIMER       = 5'd7;
  localparam logic [4:0] CAUSE_LOCAL_BASE  = 5'd16;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1
  } mtvec_mode_e;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - multi-stage synchronizer with rising-edge detect for one interrupt line.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_async,
  output logic irq_sync,
  output logic irq_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign irq_sync = r_sync[SYNC_STAGES-1];
  assign irq_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/csr_intc.sv
// rtl/csr_intc.sv - machine-mode CSR file with local/timer interrupt controller and trap sequencing.
module csr_intc
  import csr_pkg::*;
#(
  parameter int NIRQ        = 4,
  parameter int PC_W        = 23,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_i,
  input  logic            timer_irq,
  input  logic [2:0]      exceptions,
  input  logic            enter_isr,
  input  logic            mret,
  input  logic [11:0]     csr_addr,
  input  logic [31:0]     csr_wdata,
  input  logic            csr_we,
  output logic [31:0]     csr_rdata,
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] isr_return,
  output logic [PC_W-1:0] isr_target,
  output logic            interrupt_pending
);

  localparam logic [31:0] MIE_MASK = 32'h80 | (((32'h1 << NIRQ) - 32'h1) << 16);

  logic             r_mstatus_mie;
  logic             r_mstatus_mpie;
  logic [31:0]      r_mie;
  logic [29:0]      r_mtvec_base;
  mtvec_mode_e      r_mtvec_mode;
  logic [31:0]      r_mscratch;
  logic [31:0]      r_mepc;
  logic [31:0]      r_mcause;
  logic [NIRQ-1:0]  r_mip_loc;
  logic             r_mip_tmr;
  logic [NIRQ-1:0]  r_mirqcfg;
  logic [63:0]      r_mcycle;

  logic [NIRQ-1:0]  w_sync;
  logic [NIRQ-1:0]  w_rise;
  logic [31:0]      w_mip;
  logic [31:0]      w_active;
  logic             w_cause_valid;
  logic             w_cause_intr;
  logic [4:0]       w_cause_code;
  logic [31:0]      w_cause_next;
  logic             w_we_mip;

  for (genvar g = 0; g < NIRQ; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset     (reset),
      .irq_async (irq_i[g]),
      .irq_sync  (w_sync[g]),
      .irq_rise  (w_rise[g])
    );
  end

  always_comb begin
    w_mip           = '0;
    w_mip[7]        = r_mip_tmr;
    w_mip[16+:NIRQ] = r_mip_loc;
  end

  assign w_active          = r_mie & w_mip;
  assign interrupt_pending = r_mstatus_mie & (|w_active);
  assign w_we_mip          = csr_we && (csr_addr == CSR_MIP);

  // Lowest priority is evaluated first so that higher-priority sources overwrite it.
  always_comb begin
    w_cause_valid = 1'b0;
    w_cause_intr  = 1'b0;
    w_cause_code  = '0;
    if (exceptions[2]) begin w_cause_valid = 1'b1; w_cause_code = CAUSE_LOAD_FAULT;  end
    if (exceptions[0]) begin w_cause_valid = 1'b1; w_cause_code = CAUSE_PC_MISALIGN; end
    if (exceptions[1]) begin w_cause_valid = 1'b1; w_cause_code = CAUSE_ILLEGAL;     end
    if (r_mstatus_mie) begin
      if (w_active[7]) begin
        w_cause_valid = 1'b1;
        w_cause_intr  = 1'b1;
        w_cause_code  = CAUSE_TIMER;
      end
      for (int i = NIRQ - 1; i >= 0; i--) begin
        if (w_active[16+i]) begin
          w_cause_valid = 1'b1;
          w_cause_intr  = 1'b1;
          w_cause_code  = CAUSE_LOCAL_BASE + 5'(i);
        end
      end
    end
  end

  assign w_cause_next = {w_cause_intr, 26'd0, w_cause_code};
  assign isr_return   = PC_W'(r_mepc);
  assign isr_target   = PC_W'({r_mtvec_base, 2'b00}) +
                        ((r_mtvec_mode == MTVEC_VECTORED && w_cause_intr) ?
                         PC_W'({w_cause_code, 2'b00}) : PC_W'(0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec_base   <= '0;
      r_mtvec_mode   <= MTVEC_VECTORED;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mip_loc      <= '0;
      r_mip_tmr      <= 1'b0;
      r_mirqcfg      <= '0;
      r_mcycle       <= '0;
    end else begin
      r_mip_tmr <= timer_irq;
      // Edge latches: a new edge beats a software clear in the same cycle.
      for (int i = 0; i < NIRQ; i++) begin
        if (!r_mirqcfg[i])                         r_mip_loc[i] <= w_sync[i];
        else if (w_rise[i])                        r_mip_loc[i] <= 1'b1;
        else if (w_we_mip && !csr_wdata[16+i])     r_mip_loc[i] <= 1'b0;
      end

      if (enter_isr) begin
        r_mepc         <= 32'(pc);
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
        if (w_cause_valid) r_mcause <= w_cause_next;
      end else if (mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end

      r_mcycle <= r_mcycle + 64'd1;

      // Software writes come last so they override the hardware updates above.
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= csr_wdata[3];
            r_mstatus_mpie <= csr_wdata[7];
          end
          CSR_MIE:      r_mie <= csr_wdata & MIE_MASK;
          CSR_MTVEC: begin
            r_mtvec_base <= csr_wdata[31:2];
            r_mtvec_mode <= (csr_wdata[1:0] == 2'd1) ? MTVEC_VECTORED : MTVEC_DIRECT;
          end
          CSR_MSCRATCH: r_mscratch <= csr_wdata;
          CSR_MEPC:     r_mepc     <= csr_wdata;
          CSR_MCAUSE:   r_mcause   <= csr_wdata;
          CSR_MIRQCFG:  r_mirqcfg  <= csr_wdata[NIRQ-1:0];
          CSR_MCYCLE:   r_mcycle   <= {r_mcycle[63:32], csr_wdata};
          CSR_MCYCLEH:  r_mcycle   <= {csr_wdata, r_mcycle[31:0]};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = {24'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
      CSR_MIE:      csr_rdata = r_mie;
      CSR_MTVEC:    csr_rdata = {r_mtvec_base, r_mtvec_mode};
      CSR_MSCRATCH: csr_rdata = r_mscratch;
      CSR_MEPC:     csr_rdata = r_mepc;
      CSR_MCAUSE:   csr_rdata = r_mcause;
      CSR_MIP:      csr_rdata = w_mip;
      CSR_MIRQCFG:  csr_rdata = 32'(r_mirqcfg);
      CSR_MCYCLE:   csr_rdata = r_mcycle[31:0];
      CSR_MCYCLEH:  csr_rdata = r_mcycle[63:32];
      default:      csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_intc.sv
// tb/tb_csr_intc.sv - directed self-checking bench for csr_intc.
module tb_csr_intc;
  import csr_pkg::*;

  localparam int NIRQ = 4;
  localparam int PC_W = 23;

  logic            clk = 1'b0;
  logic            reset;
  logic [NIRQ-1:0] irq_i;
  logic            timer_irq;
  logic [2:0]      exceptions;
  logic            enter_isr;
  logic            mret;
  logic [11:0]     csr_addr;
  logic [31:0]     csr_wdata;
  logic            csr_we;
  logic [31:0]     csr_rdata;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] isr_return;
  logic [PC_W-1:0] isr_target;
  logic            interrupt_pending;

  int tests = 0;
  int fails = 0;
  logic [31:0] rv;

  csr_intc #(.NIRQ(NIRQ), .PC_W(PC_W), .SYNC_STAGES(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .irq_i             (irq_i),
    .timer_irq         (timer_irq),
    .exceptions        (exceptions),
    .enter_isr         (enter_isr),
    .mret              (mret),
    .csr_addr          (csr_addr),
    .csr_wdata         (csr_wdata),
    .csr_we            (csr_we),
    .csr_rdata         (csr_rdata),
    .pc                (pc),
    .isr_return        (isr_return),
    .isr_target        (isr_target),
    .interrupt_pending (interrupt_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_we    = 1'b1;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    rv = csr_rdata;
    chk(tag, rv, exp);
  endtask

  task automatic trap();
    enter_isr = 1'b1;
    tick();
    enter_isr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq_i = '0; timer_irq = 1'b0; exceptions = '0;
    enter_isr = 1'b0; mret = 1'b0; csr_addr = '0; csr_wdata = '0; csr_we = 1'b0; pc = '0;
    tick(); tick();
    rd_chk("rst_mtvec", CSR_MTVEC, 32'h1);
    rd_chk("rst_mstatus", CSR_MSTATUS, 32'h0);
    rd_chk("rst_mcycle", CSR_MCYCLE, 32'h0);
    chk("rst_pending", 32'(interrupt_pending), 32'h0);
    reset = 1'b1;

    // Level source 2 latency and release
    wr(CSR_MIE, 32'h0004_0000);
    wr(CSR_MSTATUS, 32'h8);
    irq_i = 4'b0100;
    tick(); tick();
    chk("lvl_rise_early", 32'(interrupt_pending), 32'h0);
    tick();
    chk("lvl_rise", 32'(interrupt_pending), 32'h1);
    irq_i = '0;
    tick(); tick();
    chk("lvl_fall_early", 32'(interrupt_pending), 32'h1);
    tick();
    chk("lvl_fall", 32'(interrupt_pending), 32'h0);

    // Edge source 0: latch, hold, clear, set-beats-clear
    wr(CSR_MIRQCFG, 32'h1);
    rd_chk("mirqcfg", CSR_MIRQCFG, 32'h1);
    irq_i = 4'b0001; tick(); irq_i = '0; tick(); tick();
    rd_chk("edge_set", CSR_MIP, 32'h0001_0000);
    tick(); tick(); tick();
    rd_chk("edge_hold", CSR_MIP, 32'h0001_0000);
    wr(CSR_MIP, 32'h0001_0000);
    rd_chk("edge_w1_keep", CSR_MIP, 32'h0001_0000);
    wr(CSR_MIP, 32'h0);
    rd_chk("edge_clr", CSR_MIP, 32'h0);
    wr(CSR_MIP, 32'hFFFF_FFFF);
    rd_chk("edge_w1_noset", CSR_MIP, 32'h0);
    irq_i = 4'b0001; tick(); irq_i = '0; tick();
    wr(CSR_MIP, 32'h0);
    rd_chk("edge_set_wins", CSR_MIP, 32'h0001_0000);
    chk("edge_not_enabled", 32'(interrupt_pending), 32'h0);
    wr(CSR_MIP, 32'h0);
    wr(CSR_MIRQCFG, 32'h0);

    // Vectored target and trap entry/return
    wr(CSR_MTVEC, 32'h101);
    wr(CSR_MIE, 32'hFFFF_FFFF);
    rd_chk("mie_mask", CSR_MIE, 32'h000F_0080);
    irq_i = 4'b0010; timer_irq = 1'b1;
    tick(); tick(); tick();
    rd_chk("mip_irq1_tmr", CSR_MIP, 32'h0002_0080);
    chk("isr_target_vec", 32'(isr_target), 32'h144);
    chk("pending_on", 32'(interrupt_pending), 32'h1);
    pc = 23'h1234;
    trap();
    rd_chk("mcause_irq1", CSR_MCAUSE, 32'h8000_0011);
    rd_chk("mstatus_enter", CSR_MSTATUS, 32'h80);
    chk("isr_return", 32'(isr_return), 32'h1234);
    chk("pending_masked", 32'(interrupt_pending), 32'h0);
    mret = 1'b1; tick(); mret = 1'b0;
    rd_chk("mstatus_mret", CSR_MSTATUS, 32'h88);
    enter_isr = 1'b1; mret = 1'b1; tick(); enter_isr = 1'b0; mret = 1'b0;
    rd_chk("enter_over_mret", CSR_MSTATUS, 32'h80);

    // Exception priority with MIE clear
    irq_i = '0; timer_irq = 1'b0;
    exceptions = 3'b111;
    #1 chk("isr_target_exc", 32'(isr_target), 32'h100);
    trap();
    rd_chk("cause_illegal", CSR_MCAUSE, 32'h2);
    exceptions = 3'b101; trap();
    rd_chk("cause_misalign", CSR_MCAUSE, 32'h0);
    exceptions = 3'b100; trap();
    rd_chk("cause_load", CSR_MCAUSE, 32'h5);
    exceptions = 3'b000; trap();
    rd_chk("cause_unchanged", CSR_MCAUSE, 32'h5);
    enter_isr = 1'b1;
    wr(CSR_MSTATUS, 32'h88);
    enter_isr = 1'b0;
    rd_chk("csr_over_hw", CSR_MSTATUS, 32'h88);

    // mcycle wrap, mtvec WARL, misc
    wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    wr(CSR_MCYCLEH, 32'hFFFF_FFFF);
    rd_chk("mcycle_lo_max", CSR_MCYCLE, 32'hFFFF_FFFF);
    rd_chk("mcycle_hi_max", CSR_MCYCLEH, 32'hFFFF_FFFF);
    tick();
    rd_chk("mcycle_lo_wrap", CSR_MCYCLE, 32'h0);
    rd_chk("mcycle_hi_wrap", CSR_MCYCLEH, 32'h0);
    wr(CSR_MTVEC, 32'h202);
    rd_chk("mtvec_warl2", CSR_MTVEC, 32'h200);
    wr(CSR_MTVEC, 32'h103);
    rd_chk("mtvec_warl3", CSR_MTVEC, 32'h100);
    wr(CSR_MSCRATCH, 32'hDEAD_BEEF);
    rd_chk("mscratch", CSR_MSCRATCH, 32'hDEAD_BEEF);
    rd_chk("unmapped", 12'h123, 32'h0);

    // Reset with an edge latch set
    wr(CSR_MIRQCFG, 32'h1);
    irq_i = 4'b0001; tick(); irq_i = '0; tick(); tick();
    rd_chk("pre_rst_edge", CSR_MIP, 32'h0001_0000);
    reset = 1'b0;
    tick();
    rd_chk("rst_mip", CSR_MIP, 32'h0);
    rd_chk("rst_mcause", CSR_MCAUSE, 32'h0);
    rd_chk("rst_mcycle_lo", CSR_MCYCLE, 32'h0);
    rd_chk("rst_mcycle_hi", CSR_MCYCLEH, 32'h0);
    rd_chk("rst_mtvec2", CSR_MTVEC, 32'h1);
    rd_chk("rst_mirqcfg", CSR_MIRQCFG, 32'h0);
    chk("rst_pending2", 32'(interrupt_pending), 32'h0);
    reset = 1'b1;
    tick();
    rd_chk("post_rst_mip", CSR_MIP, 32'h0);
    chk("post_rst_pending", 32'(interrupt_pending), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
